// File: rtl/cpu_regfile_if.sv
// cpu_regfile_if -- read/write bus of the register file.
//   asel, bsel : read port A/B register index
//   ren        : read enable (0 holds both read outputs)
//   wsel       : write register index
//   wreg       : write enable
//   wdata      : write data
//   adata/bdata: registered read data, ports A/B
//   ready      : file initialised and accepting accesses
// master drives the request side, slave is the register file.
interface cpu_regfile_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 3
);
  logic [AWIDTH-1:0] asel;
  logic [AWIDTH-1:0] bsel;
  logic              ren;
  logic [AWIDTH-1:0] wsel;
  logic              wreg;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] adata;
  logic [DWIDTH-1:0] bdata;
  logic              ready;

  modport master (
    output asel, bsel, ren, wsel, wreg, wdata,
    input  adata, bdata, ready
  );

  modport slave (
    input  asel, bsel, ren, wsel, wreg, wdata,
    output adata, bdata, ready
  );
endinterface

// File: rtl/cpu_regfile.sv
// cpu_regfile -- 2-read / 1-write register file with registered read data.
// After reset it walks every entry writing zero (CLEAR), then raises ready
// and serves accesses (RUN).
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cpu_regfile_if.slave (read selects, write port, read data, ready)
// Parameters: DWIDTH data width, AWIDTH index width (NREGS = 2**AWIDTH),
//   ZERO_R0 makes r0 hard zero, BYPASS forwards same-cycle write data to reads.
module cpu_regfile #(
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned AWIDTH  = 3,
  parameter bit          ZERO_R0 = 1'b0,
  parameter bit          BYPASS  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  cpu_regfile_if.slave  bus
);
  localparam int unsigned NREGS = 2 ** AWIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DWIDTH-1:0] adata_q, adata_d;
  logic [DWIDTH-1:0] bdata_q, bdata_d;

  // Storage is not reset; the CLEAR walk zeroes it before ready rises.
  logic [DWIDTH-1:0] mem_q [NREGS];

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] rd_a, rd_b;

  // Read value as seen by the output register: r0 forcing wins over bypass.
  always_comb begin
    rd_a = mem_q[bus.asel];
    rd_b = mem_q[bus.bsel];
    if (BYPASS && bus.wreg && (bus.wsel == bus.asel)) rd_a = bus.wdata;
    if (BYPASS && bus.wreg && (bus.wsel == bus.bsel)) rd_b = bus.wdata;
    if (ZERO_R0 && (bus.asel == '0)) rd_a = '0;
    if (ZERO_R0 && (bus.bsel == '0)) rd_b = '0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    adata_d   = adata_q;
    bdata_d   = bdata_q;
    mem_we    = 1'b0;
    mem_waddr = bus.wsel;
    mem_wdata = bus.wdata;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        adata_d   = '0;
        bdata_d   = '0;
        if (cnt_q == '1) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        mem_we = bus.wreg && !(ZERO_R0 && (bus.wsel == '0));
        if (bus.ren) begin
          adata_d = rd_a;
          bdata_d = rd_b;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      adata_q <= '0;
      bdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      adata_q <= adata_d;
      bdata_q <= bdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.adata = adata_q;
  assign bus.bdata = bdata_q;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_cpu_regfile.sv
// tb_cpu_regfile -- drives four register files (every ZERO_R0/BYPASS pairing)
// from one stimulus stream and compares each against an array-based model.
module tb_cpu_regfile;
  localparam int unsigned NCFG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  asel = '0, bsel = '0, wsel = '0;
  logic        ren = 1'b0, wreg = 1'b0;
  logic [15:0] wdata = '0;

  logic [15:0] adata_w [NCFG];
  logic [15:0] bdata_w [NCFG];
  logic        ready_w [NCFG];

  always #5 clk = ~clk;

  // cfg index bit1 = ZERO_R0, bit0 = BYPASS
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    cpu_regfile_if #(.DWIDTH(16), .AWIDTH(3)) bus ();
    assign bus.asel  = asel;
    assign bus.bsel  = bsel;
    assign bus.ren   = ren;
    assign bus.wsel  = wsel;
    assign bus.wreg  = wreg;
    assign bus.wdata = wdata;
    assign adata_w[g] = bus.adata;
    assign bdata_w[g] = bus.bdata;
    assign ready_w[g] = bus.ready;
    cpu_regfile #(
      .DWIDTH (16),
      .AWIDTH (3),
      .ZERO_R0(((g >> 1) & 1) != 0),
      .BYPASS ((g & 1) != 0)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  // Reference model
  logic [15:0] m_mem [NCFG][8];
  logic [15:0] m_a [NCFG];
  logic [15:0] m_b [NCFG];
  logic        m_ready;
  int          m_edges;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] model_read(input int c, input logic [2:0] sel);
    bit zr = ((c >> 1) & 1) != 0;
    bit bp = (c & 1) != 0;
    if (zr && sel == 0) return 16'h0000;
    if (bp && wreg && wsel == sel) return wdata;
    return m_mem[c][sel];
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_edges = 0;
    for (int c = 0; c < NCFG; c++) begin
      m_a[c] = '0;
      m_b[c] = '0;
      for (int i = 0; i < 8; i++) m_mem[c][i] = '0;
    end
  endtask

  task automatic check_all(input string what);
    for (int c = 0; c < NCFG; c++) begin
      check_eq($sformatf("%s adata c%0d", what, c), {16'h0, adata_w[c]}, {16'h0, m_a[c]});
      check_eq($sformatf("%s bdata c%0d", what, c), {16'h0, bdata_w[c]}, {16'h0, m_b[c]});
      check_eq($sformatf("%s ready c%0d", what, c), {31'h0, ready_w[c]}, {31'h0, m_ready});
    end
  endtask

  // One clock: advance the model using the current inputs, take the edge, compare.
  task automatic cycle(input string what);
    if (!m_ready) begin
      m_edges++;
      if (m_edges == 8) m_ready = 1'b1;
    end else begin
      for (int c = 0; c < NCFG; c++) begin
        if (ren) begin
          m_a[c] = model_read(c, asel);
          m_b[c] = model_read(c, bsel);
        end
        if (wreg && !((((c >> 1) & 1) != 0) && wsel == 0)) m_mem[c][wsel] = wdata;
      end
    end
    @(posedge clk);
    #1;
    check_all(what);
  endtask

  // Reset pulse placed between edges so its effect is purely asynchronous.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    rst_n = 1'b1;
  endtask

  task automatic set_in(input bit r, input logic [2:0] a, input logic [2:0] b,
                        input bit w, input logic [2:0] ws, input logic [15:0] wd);
    ren = r; asel = a; bsel = b; wreg = w; wsel = ws; wdata = wd;
  endtask

  task automatic clear_phase(input string what);
    for (int i = 0; i < 8; i++) begin
      set_in(1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
      cycle(what);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    pulse_reset();
    clear_phase("clear");

    for (int i = 0; i < 8; i++) begin
      set_in(1, 3'(i), 3'(7 - i), 0, 0, 0);
      cycle("read_zero");
    end

    set_in(0, 0, 0, 1, 3, 16'h1234); cycle("wr_r3");
    set_in(1, 3, 3, 0, 0, 0);        cycle("rd_r3");

    set_in(0, 0, 0, 1, 5, 16'h0001); cycle("wr_r5");
    set_in(1, 5, 5, 1, 5, 16'hBEEF); cycle("bypass_r5");
    set_in(1, 5, 0, 0, 0, 0);        cycle("after_r5");

    set_in(0, 0, 0, 1, 0, 16'hFFFF); cycle("wr_r0");
    set_in(1, 0, 0, 0, 0, 0);        cycle("rd_r0");

    set_in(1, 3, 3, 0, 0, 0);        cycle("rd_1234");
    set_in(0, 1, 2, 1, 3, 16'h5555); cycle("hold1");
    set_in(0, 4, 6, 0, 0, 0);        cycle("hold2");
    set_in(0, 7, 0, 0, 0, 0);        cycle("hold3");
    set_in(1, 3, 3, 0, 0, 0);        cycle("rd_5555");

    set_in(0, 0, 0, 1, 2, 16'h00AA); cycle("wr_r2");
    set_in(1, 2, 2, 0, 0, 0);        cycle("rd_r2");
    pulse_reset();
    clear_phase("reclear");
    set_in(1, 2, 2, 0, 0, 0);        cycle("rd_r2_after");

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset();
        clear_phase("rand_clear");
      end else begin
        set_in(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
               1'($urandom), 3'($urandom), 16'($urandom));
        cycle("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_regfile.md
CPU_REGFILE -- requirements
Module: cpu_regfile

Interface
REQ-001 Parameter DWIDTH, default 16: register data width in bits.
REQ-002 Parameter AWIDTH, default 3: register index width; depth NREGS = 2**AWIDTH.
REQ-003 Parameter ZERO_R0, default 0: when 1, register 0 reads as zero and ignores writes.
REQ-004 Parameter BYPASS, default 1: when 1, a read of the register being written in the same cycle returns the new data.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 asel  input  AWIDTH  read port A register index.
REQ-008 bsel  input  AWIDTH  read port B register index.
REQ-009 ren  input  1  read enable; 0 holds both read outputs.
REQ-010 wsel  input  AWIDTH  write register index.
REQ-011 wreg  input  1  write enable.
REQ-012 wdata  input  DWIDTH  write data.
REQ-013 adata  output  DWIDTH  registered read data, port A.
REQ-014 bdata  output  DWIDTH  registered read data, port B.
REQ-015 ready  output  1  high when the file is initialised and accepting reads and writes.

Function
REQ-016 The block SHALL implement two states, CLEAR and RUN, plus an AWIDTH-bit clear counter.
REQ-017 In CLEAR, each rising edge SHALL write zero to the entry indexed by the counter and increment the counter.
REQ-018 On the edge that clears entry NREGS-1, the block SHALL enter RUN and assert ready; ready SHALL therefore rise exactly NREGS edges after rst_n deasserts.
REQ-019 In CLEAR, wreg and ren SHALL be ignored, and adata and bdata SHALL remain 0.
REQ-020 In RUN, when wreg=1 at a rising edge, the block SHALL store wdata into entry wsel; if ZERO_R0=1 and wsel=0, the write SHALL be discarded.
REQ-021 In RUN, when ren=1 at a rising edge, adata SHALL load entry asel and bdata SHALL load entry bsel, giving one-cycle read latency.
REQ-022 If BYPASS=1, ren=1, wreg=1, and wsel equals asel (or bsel), the corresponding output SHALL load wdata rather than the stored value.
REQ-023 If BYPASS=0 in the same case, the output SHALL load the pre-write stored value.
REQ-024 If ZERO_R0=1 and asel=0 (or bsel=0), the corresponding output SHALL load 0 regardless of bypass.
REQ-025 When ren=0 in RUN, adata and bdata SHALL hold their previous values; writes SHALL proceed normally.
REQ-026 asel and bsel SHALL be independent; both may equal each other or wsel in any combination.
REQ-027 Write followed by read of the same index on the next edge SHALL always return the written data.

Reset
REQ-028 While rst_n=0, asynchronously: state=CLEAR, counter=0, ready=0, adata=0, bdata=0.
REQ-029 Assertion of rst_n mid-RUN SHALL abort operation immediately; after release, the full NREGS-cycle clear SHALL repeat, and every entry SHALL read 0 afterwards.
REQ-030 Storage contents need not be reset asynchronously; the CLEAR sequence SHALL guarantee zeroed contents before ready=1.

Verification
REQ-031 Reset release, defaults: ready=0 for 8 edges and 1 after the 8th; then reading asel=0..7 -> adata=0 for every entry.
REQ-032 Write r3=0x1234, then the next cycle ren=1, asel=3, bsel=3 -> one edge later adata=bdata=0x1234.
REQ-033 Same-cycle wreg=1, wsel=5, wdata=0xBEEF, ren=1, asel=5, old r5=0x0001: BYPASS=1 -> adata=0xBEEF; BYPASS=0 -> adata=0x0001, and the following read gives 0xBEEF.
REQ-034 ZERO_R0=1: write r0=0xFFFF, then read asel=0 -> adata=0; the same write with ZERO_R0=0 -> adata=0xFFFF.
REQ-035 adata=0x1234, ren=0 for 3 cycles while asel changes and r3 is rewritten to 0x5555 -> adata stays 0x1234; ren=1 -> adata=0x5555.
REQ-036 rst_n pulsed low mid-RUN with r2=0x00AA -> adata, bdata, and ready go to 0 asynchronously; ready returns after 8 edges; reading r2 gives 0; writes during CLEAR are ignored.
